fifo_reader: RTL and testbench
==============================

# fifo_reader

Read-side controller for the team's synchronous FIFO (`push`/`full`/`alFull` on the write side, `pop`/`vld`/`data_out` on the read side). It drives the FIFO's `pop` and converts its combinational pop-and-sample read port into a registered valid/ready stream. A two-entry skid buffer gives full throughput with no combinational path from `m_ready` to `fifo_pop`. It sits between the FIFO read port and any downstream valid/ready consumer, and also provides flush, enable and a transfer counter.

## Interface
- `DW`, 24, data width; must equal the FIFO's `DW`.
- `CNTW`, 16, width of the transfer counter.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `en` input 1: when 0, no new words are popped; buffered words still drain.
- `flush` input 1: synchronous; discards both buffered words.
- `fifo_pop` output 1: to FIFO `pop`.
- `fifo_vld` input 1: from FIFO `vld`.
- `fifo_data` input DW: from FIFO `data_out`; valid whenever `fifo_vld`=1.
- `m_valid` output 1: output word valid.
- `m_ready` input 1: downstream accepts.
- `m_data` output DW: output word.
- `xfer_cnt` output CNTW: count of output transfers; wraps modulo 2^CNTW.

## Operation
- Storage is a main register (drives `m_data`) and a skid register.
- The occupancy state `occ` takes three values: EMPTY (0), ONE (1), TWO (2).
- `m_valid` = (occ != EMPTY). It is decoded from the state register only.
- `fifo_pop` = `en` && !`flush` && (occ != TWO). It depends only on state, `en` and `flush`, never on `m_ready` or `fifo_vld`.
  - `pop` with `fifo_vld`=0 is legal; the FIFO ignores it.
- `acc_in` = `fifo_pop` && `fifo_vld`: a word is taken from the FIFO this cycle.
- `acc_out` = `m_valid` && `m_ready`: a word leaves on the output this cycle.
- State transitions (`flush`=0):
  - EMPTY: `acc_in` → ONE, main ← `fifo_data`.
  - ONE: `acc_in` && !`acc_out` → TWO, skid ← `fifo_data`.
  - ONE: `acc_in` && `acc_out` → ONE, main ← `fifo_data`.
  - ONE: !`acc_in` && `acc_out` → EMPTY.
  - ONE: no event → ONE, hold.
  - TWO: `acc_out` → ONE, main ← skid.
  - TWO: no `acc_out` → TWO, hold. `acc_in` is impossible in TWO.
- Ordering: words leave `m_data` in exactly FIFO pop order. No word is dropped or duplicated unless `flush` is asserted.
- Stability: while `m_valid`=1 and `m_ready`=0, `m_data` holds its value.
- `flush`=1:
  - Next state is EMPTY.
  - `fifo_pop`=0 that cycle.
  - Data registers are left unchanged, since they are don't-care when EMPTY.
  - An `acc_out` in the same cycle still counts in `xfer_cnt`.
  - FIFO contents are not affected.
- `en`=0: `fifo_pop`=0 and the buffer drains normally. `en` returning to 1 resumes popping on that same cycle.
- `xfer_cnt` increments by 1 on each `acc_out` and wraps from 2^CNTW−1 to 0. It is not cleared by `flush`.

## Timing
- Reset values (async assert, sync release on clk):
  - occ=EMPTY, `m_valid`=0, `m_data`=0, skid=0, `xfer_cnt`=0.
  - `fifo_pop`=0 while `rst`=1.
- Reset mid-transfer discards both buffered words immediately. Downstream must not sample during `rst`.
- Latency: a word accepted at edge N (`acc_in` in cycle N) appears on `m_data` with `m_valid`=1 in cycle N+1 when occ was EMPTY, or when occ was ONE with `acc_out`.
- Throughput: with `m_ready` held at 1 and the FIFO non-empty, there is one word per cycle (occ stays ONE).
- After a stall (occ=TWO), `fifo_pop` reasserts one cycle after the first `acc_out`.
- The only combinational input-to-output path is `en`/`flush` → `fifo_pop`. `m_ready` → outputs is registered only.

## Test plan
- Reset, then load FIFO with 0x000001..0x000008, `en`=1, `m_ready`=1 → `m_data` 0x000001..0x000008 on 8 consecutive cycles, first one cycle after the first `acc_in`; `xfer_cnt`=8; `m_valid`=0 after.
- Same 8 words, `m_ready` toggling 1/0 pseudo-randomly → order preserved, no drops or duplicates; `m_data` stable whenever `m_valid`&&!`m_ready`; occ never exceeds TWO; `fifo_pop`=0 whenever occ=TWO.
- `m_ready`=0 with FIFO holding 5 words → exactly 2 popped, `fifo_pop`=0 thereafter, FIFO retains 3. Raise `m_ready` → all 5 delivered in order.
- occ=TWO holding 0xA, 0xB, assert `flush` for 1 cycle with `m_ready`=0 → `m_valid`=0 next cycle, `fifo_pop`=0 during flush; the next word out is the FIFO's next word, not 0xB; `xfer_cnt` unchanged.
- `en`=0 with occ=ONE and `m_ready`=1 → one word out, then `m_valid`=0, `fifo_pop`=0; `en`=1 → popping resumes the same cycle.
- Preload `xfer_cnt` to 2^CNTW−1 via transfers (CNTW=4: 15 words), then 1 more → `xfer_cnt`=0. Assert `rst` asynchronously mid-stream → `m_valid`=0, `fifo_pop`=0, `xfer_cnt`=0 without waiting for a clock edge.

Source files
------------

// File: rtl/fifo_reader.sv
// rtl/fifo_reader.sv - FIFO read-side controller: two-entry skid buffer to valid/ready stream
module fifo_reader #(
    parameter int DW   = 24,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            flush,
    output logic            fifo_pop,
    input  logic            fifo_vld,
    input  logic [DW-1:0]   fifo_data,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [DW-1:0]   m_data,
    output logic [CNTW-1:0] xfer_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

    occ_t          occ;
    occ_t          occ_next;
    logic [DW-1:0] main_q;
    logic [DW-1:0] skid_q;
    logic [DW-1:0] main_next;
    logic [DW-1:0] skid_next;
    logic          acc_in;
    logic          acc_out;

    // Pop depends only on state, en and flush so m_ready never reaches the FIFO combinationally.
    assign fifo_pop = !rst && en && !flush && (occ != TWO);
    assign m_valid  = (occ != EMPTY);
    assign m_data   = main_q;
    assign acc_in   = fifo_pop && fifo_vld;
    assign acc_out  = m_valid && m_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ      <= EMPTY;
            main_q   <= '0;
            skid_q   <= '0;
            xfer_cnt <= '0;
        end else begin
            occ    <= occ_next;
            main_q <= main_next;
            skid_q <= skid_next;
            if (acc_out) begin
                xfer_cnt <= xfer_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        occ_next  = occ;
        main_next = main_q;
        skid_next = skid_q;
        case (occ)
            EMPTY: begin
                if (acc_in) begin
                    occ_next  = ONE;
                    main_next = fifo_data;
                end
            end
            ONE: begin
                if (acc_in && !acc_out) begin
                    occ_next  = TWO;
                    skid_next = fifo_data;
                end else if (acc_in && acc_out) begin
                    main_next = fifo_data;
                end else if (acc_out) begin
                    occ_next = EMPTY;
                end
            end
            TWO: begin
                if (acc_out) begin
                    occ_next  = ONE;
                    main_next = skid_q;
                end
            end
            default: begin
                occ_next = EMPTY;
            end
        endcase
        // Flush empties the buffer; stored words become don't-care and are left untouched.
        if (flush) begin
            occ_next  = EMPTY;
            main_next = main_q;
            skid_next = skid_q;
        end
    end

endmodule

// File: tb/tb_fifo_reader.sv
// tb/tb_fifo_reader.sv - randomized scoreboard bench for fifo_reader against a queue-level model
module tb_fifo_reader;

    localparam int DW   = 24;
    localparam int CNTW = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            en = 1'b1;
    logic            flush = 1'b0;
    logic            fifo_pop;
    logic            fifo_vld;
    logic [DW-1:0]   fifo_data;
    logic            m_valid;
    logic            m_ready = 1'b1;
    logic [DW-1:0]   m_data;
    logic [CNTW-1:0] xfer_cnt;

    int checks = 0;
    int failures = 0;

    fifo_reader #(.DW(DW), .CNTW(CNTW)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .flush     (flush),
        .fifo_pop  (fifo_pop),
        .fifo_vld  (fifo_vld),
        .fifo_data (fifo_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .xfer_cnt  (xfer_cnt)
    );

    always #5 clk = ~clk;

    // Source FIFO: array with read/write indices, combinational read port.
    logic [DW-1:0] mem [0:1023];
    int wr = 0;
    int rd = 0;
    assign fifo_vld  = (rd != wr);
    assign fifo_data = mem[rd[9:0]];

    always @(posedge clk) begin
        if (fifo_pop && fifo_vld) rd <= rd + 1;
    end

    task automatic push(input logic [DW-1:0] d);
        mem[wr[9:0]] = d;
        wr = wr + 1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: words held by the reader, in order, plus a transfer count.
    logic [DW-1:0]   expq [$];
    logic [CNTW-1:0] exp_cnt = '0;
    logic            hold_prev = 1'b0;
    logic [DW-1:0]   prev_data = '0;

    task automatic model_reset();
        expq.delete();
        exp_cnt   = '0;
        hold_prev = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("m_valid", {31'd0, m_valid}, {31'd0, expq.size() != 0});
            chk("fifo_pop", {31'd0, fifo_pop}, {31'd0, en && !flush && (expq.size() < 2)});
            chk("xfer_cnt", {28'd0, xfer_cnt}, {28'd0, exp_cnt});
            if (hold_prev) chk("m_data_stable", {8'd0, m_data}, {8'd0, prev_data});
            if (m_valid && m_ready) begin
                if (expq.size() == 0) begin
                    chk("unexpected_word", {8'd0, m_data}, 32'hFFFF_FFFF);
                end else begin
                    chk("m_data", {8'd0, m_data}, {8'd0, expq[0]});
                    void'(expq.pop_front());
                end
                exp_cnt = exp_cnt + 1'b1;
            end
            if (flush) expq.delete();
            if (fifo_pop && fifo_vld) expq.push_back(fifo_data);
            hold_prev = m_valid && !m_ready;
            prev_data = m_data;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input bit rnd);
        bit done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            if (rd == wr && !m_valid && expq.size() == 0) done = 1'b1;
            else begin
                m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                step();
            end
        end
        m_ready = 1'b1;
        chk("drain_timeout", {31'd0, done}, 32'd1);
    endtask

    initial begin
        logic [CNTW-1:0] saved;
        int rd0;
        int k;

        // Reset state, with en=1 to show pop stays low during reset.
        #2;
        chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_fifo_pop", {31'd0, fifo_pop}, 32'd0);
        chk("rst_xfer_cnt", {28'd0, xfer_cnt}, 32'd0);
        chk("rst_m_data", {8'd0, m_data}, 32'd0);
        en = 1'b0;
        model_reset();
        step();
        step();
        rst = 1'b0;

        // Full-throughput burst of 1..8.
        for (int i = 1; i <= 8; i++) push(DW'(i));
        en = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 9; i++) step();
        chk("burst_cnt", {28'd0, xfer_cnt}, 32'd8);
        chk("burst_empty", {31'd0, m_valid}, 32'd0);

        // Same pattern with random backpressure.
        for (int i = 1; i <= 8; i++) push(DW'(i));
        drain(1'b1);
        for (int i = 0; i < 40; i++) push(DW'($urandom));
        drain(1'b1);

        // Stall with 5 words: exactly two taken.
        en = 1'b0;
        m_ready = 1'b0;
        step();
        rd0 = rd;
        for (int i = 0; i < 5; i++) push(DW'(24'h100 + i));
        en = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("stall_popped", rd - rd0, 32'd2);
        chk("stall_left", wr - rd, 32'd3);
        chk("stall_pop_low", {31'd0, fifo_pop}, 32'd0);
        drain(1'b0);

        // Flush while holding 0xA, 0xB.
        en = 1'b0;
        m_ready = 1'b0;
        push(24'hA);
        push(24'hB);
        push(24'hC);
        en = 1'b1;
        step();
        step();
        chk("pre_flush_data", {8'd0, m_data}, 32'hA);
        saved = xfer_cnt;
        flush = 1'b1;
        #1;
        chk("flush_pop_low", {31'd0, fifo_pop}, 32'd0);
        step();
        flush = 1'b0;
        chk("post_flush_valid", {31'd0, m_valid}, 32'd0);
        chk("flush_cnt_hold", {28'd0, xfer_cnt}, {28'd0, saved});
        step();
        chk("after_flush_word", {8'd0, m_data}, 32'hC);
        drain(1'b0);

        // en=0 with one word buffered and m_ready=1.
        for (int i = 0; i < 4; i++) push(DW'(24'h200 + i));
        step();
        step();
        en = 1'b0;
        step();
        chk("en_off_valid", {31'd0, m_valid}, 32'd0);
        chk("en_off_pop", {31'd0, fifo_pop}, 32'd0);
        en = 1'b1;
        #1;
        chk("en_on_pop", {31'd0, fifo_pop}, 32'd1);
        drain(1'b0);

        // Counter wrap: bring it to 15, then one more.
        k = int'(4'd15 - exp_cnt);
        for (int i = 0; i < k; i++) push(DW'($urandom));
        drain(1'b0);
        chk("cnt_max", {28'd0, xfer_cnt}, 32'd15);
        push(24'h777);
        drain(1'b0);
        chk("cnt_wrap", {28'd0, xfer_cnt}, 32'd0);

        // Asynchronous reset mid-stream.
        for (int i = 0; i < 6; i++) push(DW'(24'h300 + i));
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("arst_fifo_pop", {31'd0, fifo_pop}, 32'd0);
        chk("arst_xfer_cnt", {28'd0, xfer_cnt}, 32'd0);
        model_reset();
        step();
        rst = 1'b0;
        drain(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
